// File: rtl/adc_pair_framer_if.sv
// adc_pair_framer_if: ADC capture, FIFO write and status signals of the pair framer
interface adc_pair_framer_if;
  logic        start;
  logic        a_en;
  logic [15:0] a_data;
  logic        b_en;
  logic [15:0] b_data;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [15:0] fifo_din;
  logic        blk_done;
  logic        busy;
  logic [15:0] overflow_cnt;
  logic [7:0]  mismatch_cnt;
  modport master (
    input  start, a_en, a_data, b_en, b_data, fifo_full,
    output fifo_wr_en, fifo_din, blk_done, busy, overflow_cnt, mismatch_cnt
  );
  modport slave (
    output start, a_en, a_data, b_en, b_data, fifo_full,
    input  fifo_wr_en, fifo_din, blk_done, busy, overflow_cnt, mismatch_cnt
  );
endinterface

// File: rtl/adc_pair_framer.sv
// adc_pair_framer: pairs ch A/B ADC samples and frames them into header + BLOCK_LEN pair blocks
module adc_pair_framer #(
  parameter int          BLOCK_LEN    = 256,
  parameter int          PAIR_TIMEOUT = 64,
  parameter logic [7:0]  HDR_TAG      = 8'hA5
) (
  input logic clk,
  input logic rst,
  adc_pair_framer_if.master io
);
  localparam int IW = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam int TW = $clog2(PAIR_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, COLLECT, HDR, WR_A, WR_B, PAD} state_t;
  state_t state, state_nx;
  logic [2:0] a_s, b_s;
  logic a_rise, b_rise, have_a, have_b;
  logic [11:0] a_cap, b_cap, pa, pb;
  logic [TW-1:0] timer;
  logic [IW-1:0] pair_idx;
  logic [7:0] seq, mis;
  logic [15:0] ovf;
  logic pad_hi, idle, one, tmo, rep, clr, pair_done, commit, last, pad_wr, blk_end;
  assign a_rise = a_s[1] & ~a_s[2];
  assign b_rise = b_s[1] & ~b_s[2];
  assign idle = state == IDLE;
  assign one = have_a ^ have_b;
  assign tmo = one && timer == TW'(PAIR_TIMEOUT - 1);
  assign pair_done = state == COLLECT && io.start && have_a && have_b;
  assign commit = pair_done && !io.fifo_full;
  assign clr = idle || pair_done || tmo;
  assign rep = !clr && ((a_rise && have_a) || (b_rise && have_b));
  assign last = pair_idx == IW'(BLOCK_LEN - 1);
  assign pad_wr = state == PAD && !io.fifo_full;
  assign blk_end = last && (state == WR_B || (pad_wr && pad_hi));
  assign io.busy = !idle;
  assign io.overflow_cnt = ovf;
  assign io.mismatch_cnt = mis;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_s <= '0;
      b_s <= '0;
      have_a <= 1'b0;
      have_b <= 1'b0;
      a_cap <= '0;
      b_cap <= '0;
      pa <= '0;
      pb <= '0;
      timer <= '0;
      pair_idx <= '0;
      seq <= '0;
      pad_hi <= 1'b0;
      ovf <= '0;
      mis <= '0;
    end else begin
      state <= state_nx;
      a_s <= {a_s[1:0], io.a_en};
      b_s <= {b_s[1:0], io.b_en};
      // flags are released at commit so edges during the write burst seed the next pair
      have_a <= !idle && (a_rise || (have_a && !clr));
      have_b <= !idle && (b_rise || (have_b && !clr));
      a_cap <= a_rise ? io.a_data[11:0] : a_cap;
      b_cap <= b_rise ? io.b_data[11:0] : b_cap;
      pa <= commit ? a_cap : pa;
      pb <= commit ? b_cap : pb;
      timer <= (!one || clr || rep) ? '0 : timer + TW'(1);
      mis <= ((tmo || rep) && mis != 8'hFF) ? mis + 8'd1 : mis;
      ovf <= (pair_done && io.fifo_full && ovf != 16'hFFFF) ? ovf + 16'd1 : ovf;
      if (state == WR_B || (pad_wr && pad_hi))
        pair_idx <= last ? '0 : pair_idx + IW'(1);
      seq <= blk_end ? seq + 8'd1 : seq;
      pad_hi <= state == PAD && (pad_hi ^ pad_wr);
    end
  end
  always_comb begin
    state_nx = state;
    io.fifo_wr_en = 1'b0;
    io.fifo_din = '0;
    io.blk_done = blk_end;
    case (state)
      IDLE:    state_nx = io.start ? COLLECT : IDLE;
      COLLECT: state_nx = !io.start ? (pair_idx != '0 ? PAD : IDLE)
                        : commit ? (pair_idx == '0 ? HDR : WR_A) : COLLECT;
      HDR: begin
        io.fifo_wr_en = 1'b1;
        io.fifo_din = {HDR_TAG, seq};
        state_nx = WR_A;
      end
      WR_A: begin
        io.fifo_wr_en = 1'b1;
        io.fifo_din = {4'h0, pa};
        state_nx = WR_B;
      end
      WR_B: begin
        io.fifo_wr_en = 1'b1;
        io.fifo_din = {4'h0, pb};
        state_nx = (last && !io.start) ? IDLE : COLLECT;
      end
      PAD: begin
        io.fifo_wr_en = pad_wr;
        io.fifo_din = pad_wr ? 16'h8000 : 16'h0000;
        state_nx = blk_end ? IDLE : PAD;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_adc_pair_framer.sv
// tb_adc_pair_framer: directed scenario bench for adc_pair_framer with BLOCK_LEN=4
module tb_adc_pair_framer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int passed = 0;
  logic [15:0] words[$];
  int dones[$];
  adc_pair_framer_if io();
  adc_pair_framer #(.BLOCK_LEN(4), .PAIR_TIMEOUT(64), .HDR_TAG(8'hA5)) dut (
    .clk(clk), .rst(rst), .io(io.master)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (io.fifo_wr_en) begin
      words.push_back(io.fifo_din);
      if (io.blk_done) dones.push_back(words.size() - 1);
    end else if (io.blk_done) dones.push_back(-1);
  end
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic do_reset;
    rst = 1'b1;
    io.start = 1'b0;
    io.a_en = 1'b0;
    io.b_en = 1'b0;
    io.a_data = '0;
    io.b_data = '0;
    io.fifo_full = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(2);
    words.delete();
    dones.delete();
  endtask
  task automatic pair(input logic [15:0] a, input logic [15:0] b);
    io.a_data = a;
    io.b_data = b;
    io.a_en = 1'b1;
    io.b_en = 1'b1;
    cyc(4);
    io.a_en = 1'b0;
    io.b_en = 1'b0;
    cyc(8);
  endtask
  task automatic test_reset;
    do_reset();
    total++; if (io.fifo_wr_en !== 1'b0) $display("FAIL rst_wr_en got %b want 0", io.fifo_wr_en); else passed++;
    total++; if (io.fifo_din !== 16'h0) $display("FAIL rst_din got %h want 0000", io.fifo_din); else passed++;
    total++; if (io.blk_done !== 1'b0) $display("FAIL rst_blk_done got %b want 0", io.blk_done); else passed++;
    total++; if (io.busy !== 1'b0) $display("FAIL rst_busy got %b want 0", io.busy); else passed++;
    total++; if (io.overflow_cnt !== 16'h0) $display("FAIL rst_ovf got %h want 0", io.overflow_cnt); else passed++;
    total++; if (io.mismatch_cnt !== 8'h0) $display("FAIL rst_mis got %h want 0", io.mismatch_cnt); else passed++;
  endtask
  task automatic test_block;
    logic [15:0] exp[$];
    int d;
    do_reset();
    io.start = 1'b1;
    cyc(1);
    total++; if (io.busy !== 1'b1) $display("FAIL t1_busy got %b want 1", io.busy); else passed++;
    for (int i = 0; i < 4; i++) pair(16'h0123 + 16'(i), 16'h0456 + 16'(i));
    exp = '{16'hA500, 16'h0123, 16'h0456, 16'h0124, 16'h0457, 16'h0125, 16'h0458, 16'h0126, 16'h0459};
    total++; if (words.size() !== exp.size()) $display("FAIL t1_count got %0d want %0d", words.size(), exp.size()); else passed++;
    for (int i = 0; i < exp.size(); i++) begin
      logic [15:0] got;
      got = (i < words.size()) ? words[i] : 16'hxxxx;
      total++; if (got !== exp[i]) $display("FAIL t1_word%0d got %h want %h", i, got, exp[i]); else passed++;
    end
    d = (dones.size() == 1) ? dones[0] : -2;
    total++; if (d !== 8) $display("FAIL t1_blk_done got %0d want 8", d); else passed++;
    io.start = 1'b0;
    cyc(4);
    total++; if (io.busy !== 1'b0) $display("FAIL t1_idle_busy got %b want 0", io.busy); else passed++;
  endtask
  task automatic test_mismatch;
    logic [15:0] exp[$];
    do_reset();
    io.start = 1'b1;
    cyc(1);
    io.a_data = 16'h0111;
    io.a_en = 1'b1;
    cyc(4);
    io.a_en = 1'b0;
    cyc(80);
    total++; if (io.mismatch_cnt !== 8'd1) $display("FAIL t2_timeout_mis got %0d want 1", io.mismatch_cnt); else passed++;
    total++; if (words.size() !== 0) $display("FAIL t2_no_write got %0d want 0", words.size()); else passed++;
    io.a_data = 16'h0111;
    io.a_en = 1'b1;
    cyc(4);
    io.a_en = 1'b0;
    cyc(4);
    io.a_data = 16'h0222;
    io.a_en = 1'b1;
    cyc(4);
    io.a_en = 1'b0;
    cyc(4);
    io.b_data = 16'h0333;
    io.b_en = 1'b1;
    cyc(4);
    io.b_en = 1'b0;
    cyc(8);
    total++; if (io.mismatch_cnt !== 8'd2) $display("FAIL t2_repeat_mis got %0d want 2", io.mismatch_cnt); else passed++;
    exp = '{16'hA500, 16'h0222, 16'h0333};
    total++; if (words.size() !== exp.size()) $display("FAIL t2_count got %0d want %0d", words.size(), exp.size()); else passed++;
    for (int i = 0; i < exp.size(); i++) begin
      logic [15:0] got;
      got = (i < words.size()) ? words[i] : 16'hxxxx;
      total++; if (got !== exp[i]) $display("FAIL t2_word%0d got %h want %h", i, got, exp[i]); else passed++;
    end
  endtask
  task automatic test_overflow;
    logic [15:0] exp[$];
    int d;
    do_reset();
    io.start = 1'b1;
    io.fifo_full = 1'b1;
    cyc(1);
    for (int i = 0; i < 3; i++) pair(16'h0300 + 16'(i), 16'h0400 + 16'(i));
    io.fifo_full = 1'b0;
    total++; if (io.overflow_cnt !== 16'd3) $display("FAIL t3_ovf got %0d want 3", io.overflow_cnt); else passed++;
    total++; if (words.size() !== 0) $display("FAIL t3_dropped got %0d want 0", words.size()); else passed++;
    for (int i = 3; i < 7; i++) pair(16'h0300 + 16'(i), 16'h0400 + 16'(i));
    exp = '{16'hA500, 16'h0303, 16'h0403, 16'h0304, 16'h0404, 16'h0305, 16'h0405, 16'h0306, 16'h0406};
    total++; if (words.size() !== exp.size()) $display("FAIL t3_count got %0d want %0d", words.size(), exp.size()); else passed++;
    for (int i = 0; i < exp.size(); i++) begin
      logic [15:0] got;
      got = (i < words.size()) ? words[i] : 16'hxxxx;
      total++; if (got !== exp[i]) $display("FAIL t3_word%0d got %h want %h", i, got, exp[i]); else passed++;
    end
    d = (dones.size() == 1) ? dones[0] : -2;
    total++; if (d !== 8) $display("FAIL t3_blk_done got %0d want 8", d); else passed++;
    total++; if (io.overflow_cnt !== 16'd3) $display("FAIL t3_ovf_final got %0d want 3", io.overflow_cnt); else passed++;
  endtask
  task automatic test_pad;
    logic [15:0] exp[$];
    logic [15:0] got;
    int d;
    do_reset();
    io.start = 1'b1;
    cyc(1);
    for (int i = 0; i < 2; i++) pair(16'h0010 + 16'(i), 16'h0020 + 16'(i));
    io.start = 1'b0;
    cyc(12);
    exp = '{16'hA500, 16'h0010, 16'h0020, 16'h0011, 16'h0021, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
    total++; if (words.size() !== exp.size()) $display("FAIL t4_count got %0d want %0d", words.size(), exp.size()); else passed++;
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < words.size()) ? words[i] : 16'hxxxx;
      total++; if (got !== exp[i]) $display("FAIL t4_word%0d got %h want %h", i, got, exp[i]); else passed++;
    end
    d = (dones.size() == 1) ? dones[0] : -2;
    total++; if (d !== 8) $display("FAIL t4_blk_done got %0d want 8", d); else passed++;
    total++; if (io.busy !== 1'b0) $display("FAIL t4_busy got %b want 0", io.busy); else passed++;
    total++; if (io.overflow_cnt !== 16'd0) $display("FAIL t4_ovf got %0d want 0", io.overflow_cnt); else passed++;
    io.start = 1'b1;
    cyc(2);
    pair(16'h0055, 16'h0066);
    got = (words.size() > 9) ? words[9] : 16'hxxxx;
    total++; if (got !== 16'hA501) $display("FAIL t4_next_hdr got %h want a501", got); else passed++;
    got = (words.size() > 10) ? words[10] : 16'hxxxx;
    total++; if (got !== 16'h0055) $display("FAIL t4_next_a got %h want 0055", got); else passed++;
  endtask
  task automatic test_reset_midblock;
    logic [15:0] exp[$];
    logic [15:0] got;
    bit found;
    do_reset();
    io.start = 1'b1;
    cyc(1);
    io.a_data = 16'h0111;
    io.a_en = 1'b1;
    cyc(4);
    io.a_en = 1'b0;
    cyc(80);
    for (int i = 0; i < 4; i++) pair(16'h0100 + 16'(i), 16'h0200 + 16'(i));
    total++; if (io.mismatch_cnt !== 8'd1) $display("FAIL t5_pre_mis got %0d want 1", io.mismatch_cnt); else passed++;
    io.a_data = 16'h0ABC;
    io.b_data = 16'h0DEF;
    io.a_en = 1'b1;
    io.b_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(1);
      if (io.fifo_wr_en && io.fifo_din === 16'h0ABC) found = 1'b1;
    end
    total++; if (found !== 1'b1) $display("FAIL t5_reach_wr_a got %b want 1", found); else passed++;
    got = (words.size() > 0) ? words[words.size() - 1] : 16'hxxxx;
    total++; if (got !== 16'hA501) $display("FAIL t5_hdr_seq1 got %h want a501", got); else passed++;
    rst = 1'b1;
    io.a_en = 1'b0;
    io.b_en = 1'b0;
    #1;
    total++; if (io.fifo_wr_en !== 1'b0) $display("FAIL t5_async_wr_en got %b want 0", io.fifo_wr_en); else passed++;
    total++; if (io.mismatch_cnt !== 8'd0) $display("FAIL t5_mis_clr got %0d want 0", io.mismatch_cnt); else passed++;
    total++; if (io.busy !== 1'b0) $display("FAIL t5_busy got %b want 0", io.busy); else passed++;
    cyc(2);
    rst = 1'b0;
    cyc(2);
    words.delete();
    dones.delete();
    io.start = 1'b1;
    cyc(2);
    pair(16'h00AA, 16'h00BB);
    exp = '{16'hA500, 16'h00AA, 16'h00BB};
    total++; if (words.size() !== exp.size()) $display("FAIL t5_count got %0d want %0d", words.size(), exp.size()); else passed++;
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < words.size()) ? words[i] : 16'hxxxx;
      total++; if (got !== exp[i]) $display("FAIL t5_word%0d got %h want %h", i, got, exp[i]); else passed++;
    end
  endtask
  task automatic test_skew;
    logic [15:0] exp[$];
    do_reset();
    io.start = 1'b1;
    cyc(1);
    io.b_data = 16'h00B6;
    io.b_en = 1'b1;
    cyc(5);
    io.a_data = 16'h00A6;
    io.a_en = 1'b1;
    cyc(4);
    io.a_en = 1'b0;
    io.b_en = 1'b0;
    cyc(10);
    exp = '{16'hA500, 16'h00A6, 16'h00B6};
    total++; if (words.size() !== exp.size()) $display("FAIL t6_count got %0d want %0d", words.size(), exp.size()); else passed++;
    for (int i = 0; i < exp.size(); i++) begin
      logic [15:0] got;
      got = (i < words.size()) ? words[i] : 16'hxxxx;
      total++; if (got !== exp[i]) $display("FAIL t6_word%0d got %h want %h", i, got, exp[i]); else passed++;
    end
    total++; if (io.mismatch_cnt !== 8'd0) $display("FAIL t6_mis got %0d want 0", io.mismatch_cnt); else passed++;
  endtask
  initial begin
    test_reset();
    test_block();
    test_mismatch();
    test_overflow();
    test_pad();
    test_reset_midblock();
    test_skew();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
